// File: rtl/axi4_bram_slave_if.sv
// AXI4 read/write channel bundle between the polynomial master and the BRAM slave.
// The slave modport exposes the memory side; the master modport is the initiator side.
interface axi4_bram_slave_if #(
  parameter int memWidth      = 8,
  parameter int addressLength = 5
);
  logic [3:0]               ARID;
  logic [addressLength-1:0] ARADDR;
  logic [1:0]               ARBURST;
  logic                     ARVALID;
  logic                     ARREADY;
  logic [7:0]               ARLEN;
  logic [2:0]               ARSIZE;
  logic [3:0]               RID;
  logic [memWidth-1:0]      RDATA;
  logic                     RLAST;
  logic                     RVALID;
  logic                     RREADY;
  logic [1:0]               RRESP;
  logic [3:0]               AWID;
  logic [addressLength-1:0] AWADDR;
  logic [1:0]               AWBURST;
  logic                     AWVALID;
  logic                     AWREADY;
  logic [7:0]               AWLEN;
  logic [2:0]               AWSIZE;
  logic [3:0]               WID;
  logic [memWidth-1:0]      WDATA;
  logic                     WLAST;
  logic                     WVALID;
  logic                     WREADY;
  logic [3:0]               BID;
  logic [1:0]               BRESP;
  logic                     BVALID;
  logic                     BREADY;

  modport slave (
    input  ARID, ARADDR, ARBURST, ARVALID, ARLEN, ARSIZE, RREADY,
    input  AWID, AWADDR, AWBURST, AWVALID, AWLEN, AWSIZE,
    input  WID, WDATA, WLAST, WVALID, BREADY,
    output ARREADY, RID, RDATA, RLAST, RVALID, RRESP,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport master (
    output ARID, ARADDR, ARBURST, ARVALID, ARLEN, ARSIZE, RREADY,
    output AWID, AWADDR, AWBURST, AWVALID, AWLEN, AWSIZE,
    output WID, WDATA, WLAST, WVALID, BREADY,
    input  ARREADY, RID, RDATA, RLAST, RVALID, RRESP,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_bram_slave.sv
// AXI4 BRAM slave: memDepth x memWidth register array with independent read and
// write channel FSMs, FIXED/INCR/WRAP bursts of single-byte beats, ID echo, SLVERR.
module axi4_bram_slave #(
  parameter int memWidth      = 8,
  parameter int memDepth      = 32,
  parameter int addressLength = 5
) (
  input logic              ACLK,
  input logic              ARESET,
  axi4_bram_slave_if.slave bus
);
  typedef logic [addressLength-1:0] addr_t;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [memWidth-1:0] mem [memDepth];

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
           && (int'(len) < memDepth);
  endfunction

  // Reserved bursts and WRAP with an unsupported length still run, as INCR.
  function automatic burst_t eff_burst(input logic [1:0] b, input logic [7:0] len);
    if ((b == 2'b11) || ((b == 2'b10) && !wrap_len_ok(len)))
      return BURST_INCR;
    return burst_t'(b);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] b,
                                     input logic [7:0] len);
    return (size != 3'b000) || (b == 2'b11) || ((b == 2'b10) && !wrap_len_ok(len));
  endfunction

  function automatic addr_t next_addr(input addr_t a, input burst_t b, input logic [7:0] len);
    addr_t mask;
    mask = addr_t'(len);
    case (b)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | ((a + 1'b1) & mask);
      default:     return a + 1'b1;
    endcase
  endfunction

  // ---------------- read channel ----------------
  r_state_t            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [3:0]          rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [memWidth-1:0] rdata_q, rdata_d;
  addr_t               r_addr_q, r_addr_d, r_nxt;
  logic [7:0]          r_len_q, r_len_d;
  logic [7:0]          r_cnt_q, r_cnt_d;
  burst_t              r_burst_q, r_burst_d;

  assign r_nxt = next_addr(r_addr_q, r_burst_q, r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_burst_d = r_burst_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          arready_d = 1'b0;
          r_addr_d  = bus.ARADDR;
          r_len_d   = bus.ARLEN;
          r_cnt_d   = '0;
          r_burst_d = eff_burst(bus.ARBURST, bus.ARLEN);
          rid_d     = bus.ARID;
          rresp_d   = burst_err(bus.ARSIZE, bus.ARBURST, bus.ARLEN) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          rlast_d   = (bus.ARLEN == 8'd0);
          rdata_d   = mem[bus.ARADDR];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && bus.RREADY) begin
          if (r_cnt_q == r_len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = r_nxt;
            rdata_d  = mem[r_nxt];
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= BURST_FIXED;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_burst_q <= r_burst_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_t   w_state_q, w_state_d;
  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [3:0] bid_q, bid_d;
  logic [1:0] bresp_q, bresp_d;
  addr_t      w_addr_q, w_addr_d;
  logic [7:0] w_len_q, w_len_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  burst_t     w_burst_q, w_burst_d;
  logic       mem_we;

  assign mem_we = (w_state_q == W_DATA) && bus.WVALID && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (bus.AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_addr_d  = bus.AWADDR;
          w_len_d   = bus.AWLEN;
          w_cnt_d   = '0;
          w_burst_d = eff_burst(bus.AWBURST, bus.AWLEN);
          bid_d     = bus.AWID;
          bresp_d   = burst_err(bus.AWSIZE, bus.AWBURST, bus.AWLEN) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Burst ends on the beat count; WLAST is not consulted.
        if (mem_we) begin
          if (w_cnt_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = next_addr(w_addr_q, w_burst_q, w_len_q);
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bus.BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= BURST_FIXED;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
    end
  end

  // Storage has no reset; a same-edge read load sees the pre-write value.
  always_ff @(posedge ACLK) begin
    if (mem_we) mem[w_addr_q] <= bus.WDATA;
  end

  logic unused_w;
  assign unused_w = ^{bus.WID, bus.WLAST};

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RLAST   = rlast_q;
  assign bus.RID     = rid_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RDATA   = rdata_q;
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;
endmodule

// File: tb/tb_axi4_bram_slave.sv
// Scoreboard bench for axi4_bram_slave: tests push expected beats/responses,
// negedge monitors pop and compare whenever the DUT completes a handshake.
module tb_axi4_bram_slave;
  localparam int MW = 8;
  localparam int MD = 32;
  localparam int AL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_bram_slave_if #(.memWidth(MW), .addressLength(AL)) bus ();
  axi4_bram_slave #(.memWidth(MW), .memDepth(MD), .addressLength(AL)) dut (
    .ACLK(clk), .ARESET(rst), .bus(bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] id;
    logic [1:0] resp;
    logic       last;
  } rbeat_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  rbeat_t     exp_r[$];
  bresp_t     exp_b[$];
  logic [7:0] wq[$];
  logic [7:0] model [MD];
  int         checks = 0;
  int         failures = 0;
  string      cur_test = "none";
  int         stab_err;
  int         rd_cycles;
  logic       rd_lat_ok;
  logic       b_drop_ok;
  logic       xfer_ok;
  rbeat_t     mon_r, mon_e;
  bresp_t     mon_b, mon_be;

  always @(negedge clk) begin
    if (!rst && bus.RVALID && bus.RREADY) begin
      mon_r = {bus.RDATA, bus.RID, bus.RRESP, bus.RLAST};
      checks++;
      if (exp_r.size() == 0) begin
        failures++;
        $display("FAIL %s rd_unexpected got data=%h id=%h resp=%b last=%b exp none",
                 cur_test, mon_r.data, mon_r.id, mon_r.resp, mon_r.last);
      end else begin
        mon_e = exp_r.pop_front();
        if (mon_r !== mon_e) begin
          failures++;
          $display("FAIL %s rd_beat got data=%h id=%h resp=%b last=%b exp data=%h id=%h resp=%b last=%b",
                   cur_test, mon_r.data, mon_r.id, mon_r.resp, mon_r.last,
                   mon_e.data, mon_e.id, mon_e.resp, mon_e.last);
        end
      end
    end
    if (!rst && bus.BVALID && bus.BREADY) begin
      mon_b = {bus.BID, bus.BRESP};
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL %s wr_unexpected_b got id=%h resp=%b exp none", cur_test, mon_b.id, mon_b.resp);
      end else begin
        mon_be = exp_b.pop_front();
        if (mon_b !== mon_be) begin
          failures++;
          $display("FAIL %s wr_b got id=%h resp=%b exp id=%h resp=%b",
                   cur_test, mon_b.id, mon_b.resp, mon_be.id, mon_be.resp);
        end
      end
    end
  end

  function automatic void push_r(input int a, input logic [3:0] id, input logic [1:0] resp,
                                 input logic last);
    rbeat_t b;
    b = {model[a], id, resp, last};
    exp_r.push_back(b);
  endfunction

  function automatic void push_b(input logic [3:0] id, input logic [1:0] resp);
    bresp_t b;
    b = {id, resp};
    exp_b.push_back(b);
  endfunction

  // Issues one read burst and drains it; toggle selects RREADY pattern 1,0,0,...
  task automatic axi_read(input logic [4:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input bit toggle);
    int     n;
    bit     hs, done, held;
    rbeat_t snap;
    bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst;
    bus.ARSIZE = size; bus.ARID = id; bus.ARVALID = 1'b1;
    hs = 0; n = 0; rd_lat_ok = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.ARREADY;
      rd_lat_ok = !bus.RVALID;
      @(posedge clk); #1;
      n++;
    end
    bus.ARVALID = 1'b0;
    xfer_ok = hs;
    stab_err = 0;
    rd_cycles = 0;
    if (!hs) return;
    rd_lat_ok = rd_lat_ok && bus.RVALID;
    done = 0; held = 0; n = 0; snap = '0;
    while (!done && n < 200) begin
      bus.RREADY = toggle ? ((n % 3) == 0) : 1'b1;
      @(negedge clk);
      if (bus.RVALID) begin
        if (held && ({bus.RDATA, bus.RID, bus.RRESP, bus.RLAST} !== snap)) stab_err++;
        snap = {bus.RDATA, bus.RID, bus.RRESP, bus.RLAST};
        if (bus.RREADY) begin
          held = 0;
          done = bus.RLAST;
        end else begin
          held = 1;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.RREADY = 1'b0;
    rd_cycles = n;
    if (!done) xfer_ok = 1'b0;
  endtask

  // Issues AW, drives nbeats beats from wq, then takes the response if the burst completed.
  task automatic axi_write(input logic [4:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input int nbeats);
    int n;
    bit hs;
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst;
    bus.AWSIZE = size; bus.AWID = id; bus.AWVALID = 1'b1;
    hs = 0; n = 0; b_drop_ok = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = bus.AWREADY; @(posedge clk); #1; n++;
    end
    bus.AWVALID = 1'b0;
    xfer_ok = hs;
    if (!hs) return;
    for (int b = 0; b < nbeats; b++) begin
      bus.WDATA = wq[b]; bus.WID = id; bus.WLAST = (b == int'(len)); bus.WVALID = 1'b1;
      hs = 0; n = 0;
      while (!hs && n < 50) begin
        @(negedge clk); hs = bus.WREADY; @(posedge clk); #1; n++;
      end
      if (!hs) begin
        xfer_ok = 1'b0; bus.WVALID = 1'b0; return;
      end
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    if (nbeats <= int'(len)) return;
    bus.BREADY = 1'b1; hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = bus.BVALID; @(posedge clk); #1; n++;
    end
    bus.BREADY = 1'b0;
    if (!hs) begin
      xfer_ok = 1'b0; return;
    end
    @(negedge clk); b_drop_ok = !bus.BVALID; @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got %b exp 000000",
               {bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID});
    end
    checks++;
    if ({bus.RDATA, bus.RID, bus.RRESP, bus.BID, bus.BRESP} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data got %h exp 0", {bus.RDATA, bus.RID, bus.RRESP, bus.BID, bus.BRESP});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ARREADY, bus.AWREADY} !== 2'b00) begin
      failures++;
      $display("FAIL ready_before_edge got %b exp 00", {bus.ARREADY, bus.AWREADY});
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.ARREADY, bus.AWREADY} !== 2'b11) begin
      failures++;
      $display("FAIL ready_after_edge got %b exp 11", {bus.ARREADY, bus.AWREADY});
    end
  endtask

  task automatic test_incr_write();
    cur_test = "incr_write";
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) model[i] = wq[i];
    push_b(4'h0, 2'b00);
    axi_write(5'd0, 8'd3, 2'b01, 3'b000, 4'h0, 4);
    checks++;
    if (!xfer_ok) begin failures++; $display("FAIL incr_write_done got timeout exp complete"); end
    checks++;
    if (!b_drop_ok) begin failures++; $display("FAIL incr_write_bvalid_once got BVALID=1 exp 0"); end
    checks++;
    if (exp_b.size() != 0) begin
      failures++; $display("FAIL incr_write_b_pending got %0d exp 0", exp_b.size());
    end
  endtask

  task automatic test_incr_read();
    cur_test = "incr_read";
    for (int i = 0; i < 4; i++) push_r(i, 4'h1, 2'b00, i == 3);
    axi_read(5'd0, 8'd3, 2'b01, 3'b000, 4'h1, 0);
    checks++;
    if (!xfer_ok) begin failures++; $display("FAIL incr_read_done got timeout exp complete"); end
    checks++;
    if (!rd_lat_ok) begin failures++; $display("FAIL incr_read_latency got wrong RVALID timing exp 1 cycle"); end
    checks++;
    if (rd_cycles != 4) begin failures++; $display("FAIL incr_read_cycles got %0d exp 4", rd_cycles); end
    checks++;
    if (exp_r.size() != 0) begin failures++; $display("FAIL incr_read_left got %0d exp 0", exp_r.size()); end
  endtask

  task automatic test_read_backpressure();
    cur_test = "read_backpressure";
    for (int i = 0; i < 4; i++) push_r(i, 4'h1, 2'b00, i == 3);
    axi_read(5'd0, 8'd3, 2'b01, 3'b000, 4'h1, 1);
    checks++;
    if (!xfer_ok) begin failures++; $display("FAIL bp_done got timeout exp complete"); end
    checks++;
    if (stab_err != 0) begin failures++; $display("FAIL bp_stable got %0d changes exp 0", stab_err); end
    checks++;
    if (rd_cycles != 10) begin failures++; $display("FAIL bp_cycles got %0d exp 10", rd_cycles); end
    checks++;
    if (exp_r.size() != 0) begin failures++; $display("FAIL bp_left got %0d exp 0", exp_r.size()); end
  endtask

  task automatic test_wrap_read();
    cur_test = "wrap_read";
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) model[4 + i] = wq[i];
    push_b(4'h2, 2'b00);
    axi_write(5'd4, 8'd3, 2'b01, 3'b000, 4'h2, 4);
    push_r(6, 4'h3, 2'b00, 0); push_r(7, 4'h3, 2'b00, 0);
    push_r(4, 4'h3, 2'b00, 0); push_r(5, 4'h3, 2'b00, 1);
    axi_read(5'd6, 8'd3, 2'b10, 3'b000, 4'h3, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0) begin
      failures++; $display("FAIL wrap_read_left got %0d ok=%0d exp 0 ok=1", exp_r.size(), xfer_ok);
    end
    cur_test = "incr_rollover";
    wq = '{8'hE0, 8'hE1};
    model[30] = 8'hE0; model[31] = 8'hE1;
    push_b(4'h4, 2'b00);
    axi_write(5'd30, 8'd1, 2'b01, 3'b000, 4'h4, 2);
    push_r(30, 4'h5, 2'b00, 0); push_r(31, 4'h5, 2'b00, 0);
    push_r(0, 4'h5, 2'b00, 0);  push_r(1, 4'h5, 2'b00, 1);
    axi_read(5'd30, 8'd3, 2'b01, 3'b000, 4'h5, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL incr_rollover_left got r=%0d b=%0d ok=%0d exp 0 0 1", exp_r.size(), exp_b.size(), xfer_ok);
    end
  endtask

  task automatic test_errors();
    cur_test = "err_size";
    push_r(0, 4'h6, 2'b10, 0); push_r(1, 4'h6, 2'b10, 1);
    axi_read(5'd0, 8'd1, 2'b01, 3'b001, 4'h6, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0) begin
      failures++; $display("FAIL err_size_left got %0d ok=%0d exp 0 ok=1", exp_r.size(), xfer_ok);
    end
    cur_test = "err_burst11";
    wq = '{8'hB0, 8'hB1, 8'hB2};
    for (int i = 0; i < 3; i++) model[8 + i] = wq[i];
    push_b(4'h7, 2'b10);
    axi_write(5'd8, 8'd2, 2'b11, 3'b000, 4'h7, 3);
    for (int i = 0; i < 3; i++) push_r(8 + i, 4'h8, 2'b00, i == 2);
    axi_read(5'd8, 8'd2, 2'b01, 3'b000, 4'h8, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL err_burst11_left got r=%0d b=%0d ok=%0d exp 0 0 1", exp_r.size(), exp_b.size(), xfer_ok);
    end
    cur_test = "err_wrap_len";
    for (int i = 0; i < 3; i++) push_r(5 + i, 4'h9, 2'b10, i == 2);
    axi_read(5'd5, 8'd2, 2'b10, 3'b000, 4'h9, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0) begin
      failures++; $display("FAIL err_wrap_len_left got %0d ok=%0d exp 0 ok=1", exp_r.size(), xfer_ok);
    end
  endtask

  task automatic test_fixed();
    cur_test = "fixed";
    wq = '{8'h01, 8'h02, 8'h03};
    model[12] = 8'h03;
    push_b(4'hA, 2'b00);
    axi_write(5'd12, 8'd2, 2'b00, 3'b000, 4'hA, 3);
    push_r(12, 4'hB, 2'b00, 0); push_r(12, 4'hB, 2'b00, 1);
    axi_read(5'd12, 8'd1, 2'b00, 3'b000, 4'hB, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL fixed_left got r=%0d b=%0d ok=%0d exp 0 0 1", exp_r.size(), exp_b.size(), xfer_ok);
    end
    cur_test = "single_beat";
    push_r(3, 4'hC, 2'b00, 1);
    axi_read(5'd3, 8'd0, 2'b01, 3'b000, 4'hC, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0) begin
      failures++; $display("FAIL single_beat_left got %0d ok=%0d exp 0 ok=1", exp_r.size(), xfer_ok);
    end
  endtask

  task automatic test_reset_midwrite();
    cur_test = "midwrite_prefill";
    wq = '{8'h50, 8'h51, 8'h52, 8'h53};
    for (int i = 0; i < 4; i++) model[16 + i] = wq[i];
    push_b(4'h1, 2'b00);
    axi_write(5'd16, 8'd3, 2'b01, 3'b000, 4'h1, 4);
    cur_test = "midwrite";
    wq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    model[16] = 8'hC1; model[17] = 8'hC2;
    axi_write(5'd16, 8'd3, 2'b01, 3'b000, 4'h2, 2);
    checks++;
    if (!xfer_ok || bus.WREADY !== 1'b1) begin
      failures++; $display("FAIL midwrite_pre got ok=%0d WREADY=%b exp 1 1", xfer_ok, bus.WREADY);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID,
         bus.RDATA, bus.RID, bus.RRESP, bus.BID, bus.BRESP} !== 26'h0) begin
      failures++;
      $display("FAIL midwrite_reset_outputs got %h exp 0",
               {bus.ARREADY, bus.AWREADY, bus.WREADY, bus.RVALID, bus.RLAST, bus.BVALID,
                bus.RDATA, bus.RID, bus.RRESP, bus.BID, bus.BRESP});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    cur_test = "midwrite_readback";
    for (int i = 0; i < 4; i++) push_r(16 + i, 4'h3, 2'b00, i == 3);
    axi_read(5'd16, 8'd3, 2'b01, 3'b000, 4'h3, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0) begin
      failures++; $display("FAIL midwrite_readback_left got %0d ok=%0d exp 0 ok=1", exp_r.size(), xfer_ok);
    end
    cur_test = "roundtrip";
    wq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    for (int i = 0; i < 4; i++) model[20 + i] = wq[i];
    push_b(4'hE, 2'b00);
    axi_write(5'd20, 8'd3, 2'b01, 3'b000, 4'hE, 4);
    for (int i = 0; i < 4; i++) push_r(20 + i, 4'hF, 2'b00, i == 3);
    axi_read(5'd20, 8'd3, 2'b01, 3'b000, 4'hF, 0);
    checks++;
    if (!xfer_ok || exp_r.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL roundtrip_left got r=%0d b=%0d ok=%0d exp 0 0 1", exp_r.size(), exp_b.size(), xfer_ok);
    end
  endtask

  initial begin
    bus.ARID = '0; bus.ARADDR = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.ARLEN = '0; bus.ARSIZE = '0; bus.RREADY = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.AWLEN = '0; bus.AWSIZE = '0;
    bus.WID = '0; bus.WDATA = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    for (int i = 0; i < MD; i++) model[i] = '0;
    test_reset();
    test_incr_write();
    test_incr_read();
    test_read_backpressure();
    test_wrap_read();
    test_errors();
    test_fixed();
    test_reset_midwrite();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
